// File: rtl/ula_mul_ctrl_pkg.sv
// Shared ULA operation codes, multiplier FSM encodings and iteration limit.
// The ULA ADD code is the only one the multiplier drives; the rest are shared with the ULA.
package ula_mul_ctrl_pkg;

  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_AND = 3'b010;
  localparam logic [2:0] ULA_OR  = 3'b011;
  localparam logic [2:0] ULA_XOR = 3'b100;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] ITER_LIMIT = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/ula_mul_ctrl.sv
// 8x8 unsigned shift-add multiplier sequencing an external ULA for the partial-sum adds.
// MUL_EARLY_EXIT_EN: finish once the remaining multiplier bits are all zero.
module ula_mul_ctrl
  import ula_mul_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [7:0]  ula_inA,
  output logic [7:0]  ula_inB,
  output logic [2:0]  ula_ctrl,
  input  logic [7:0]  ula_out
);

  state_t           state, state_nxt;
  logic [7:0]       mcand, mplier, acc_hi, acc_lo;
  logic             carry;
  logic [CNT_W-1:0] count, count_inc, shamt;
  logic             last;
  logic [16:0]      acc_wide;
  logic [15:0]      acc_shr;

  assign count_inc = count + 1'b1;
  assign acc_wide  = {carry, acc_hi, acc_lo};

  // Normally one bit per SHIFT; early exit flushes all remaining shifts at once.
  always_comb begin
    shamt = 4'd1;
    last  = (count_inc >= ITER_LIMIT);
`ifdef MUL_EARLY_EXIT_EN
    if (mplier[7:1] == 7'd0) begin
      shamt = ITER_LIMIT - count;
      last  = 1'b1;
    end
`endif
    acc_shr = 16'(acc_wide >> shamt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    ula_inA   = 8'h00;
    ula_inB   = 8'h00;
    ula_ctrl  = ULA_ADD;
    case (state)
      IDLE:  if (start) state_nxt = ADD;
      ADD: begin
        ula_inA   = acc_hi;
        ula_inB   = mplier[0] ? mcand : 8'h00;
        state_nxt = SHIFT;
      end
      SHIFT: state_nxt = last ? FIN : ADD;
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      carry   <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand  <= op_a;
          mplier <= op_b;
          acc_hi <= '0;
          acc_lo <= '0;
          carry  <= 1'b0;
          count  <= '0;
        end
        ADD: begin
          acc_hi <= ula_out;
          // 8-bit wrap means the add overflowed.
          carry  <= (ula_out < acc_hi);
        end
        SHIFT: begin
          {acc_hi, acc_lo} <= acc_shr;
          carry            <= 1'b0;
          mplier           <= mplier >> 1;
          count            <= count_inc;
          if (last) product <= acc_shr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_mul_ctrl.sv
// Bench for ula_mul_ctrl with a behavioural ULA; expected products/latencies go through a queue.
module tb_ula_mul_ctrl;
  import ula_mul_ctrl_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0]  op_a = '0, op_b = '0;
  logic        busy, done;
  logic [15:0] product;
  logic [7:0]  ula_inA, ula_inB, ula_out;
  logic [2:0]  ula_ctrl;

  ula_mul_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product),
    .ula_inA(ula_inA), .ula_inB(ula_inB), .ula_ctrl(ula_ctrl), .ula_out(ula_out)
  );

  always #5 clk = ~clk;

  assign ula_out = (ula_ctrl == ULA_ADD) ? 8'(ula_inA + ula_inB) : 8'h00;

  int total = 0, bad = 0;

  typedef struct { logic [15:0] prod; int lat; } exp_t;
  exp_t sb[$];

  typedef struct { logic [7:0] a; logic [7:0] b; logic [15:0] prod; } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int k = 1;
    for (int i = 0; i < 8; i++) if (b[i]) k = i + 1;
    return 2 * k + 1;
`else
    return 17;
`endif
  endfunction

  // Bus and control checks while idle or running.
  always @(negedge clk) if (rst_n) begin
    total++;
    if (ula_ctrl !== ULA_ADD) begin
      bad++;
      $display("FAIL ula_ctrl got=%0h exp=%0h", ula_ctrl, ULA_ADD);
    end
    if (!busy || done) begin
      total++;
      if (ula_inA !== 8'h00 || ula_inB !== 8'h00) begin
        bad++;
        $display("FAIL ula_idle_zero got=%0h/%0h exp=0/0", ula_inA, ula_inB);
      end
    end
  end

  // Waits for IDLE, issues a multiply, returns at the first negedge after acceptance.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p, input bit hold);
    int n = 0;
    @(negedge clk);
    while (busy && n < 60) begin @(negedge clk); n++; end
    if (busy) chk("issue_timeout", 32'(busy), 32'd0);
    start = 1'b1; op_a = a; op_b = b;
    @(posedge clk);
    sb.push_back('{p, exp_lat(b)});
    @(negedge clk);
    if (!hold) start = 1'b0;
    op_a = 8'($urandom); op_b = 8'($urandom);
  endtask

  // Called at the negedge of cycle 1 after acceptance; returns at the done negedge.
  task automatic wait_done();
    int  cyc = 1;
    bit  busy_ok = 1'b1;
    exp_t e;
    while (!done && cyc < 60) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      chk("done_timeout", 32'(done), 32'd1);
      sb.delete();
    end else if (sb.size() == 0) begin
      chk("unexpected_done", 32'(done), 32'd0);
    end else begin
      e = sb.pop_front();
      chk("product", 32'(product), 32'(e.prod));
      chk("latency", 32'(cyc), 32'(e.lat));
      chk("busy_thru", 32'(busy_ok && busy), 32'd1);
    end
  endtask

  initial begin
    vecs[0] = '{8'h0D, 8'h0B, 16'h008F};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'hA5, 16'h0000};
    vecs[3] = '{8'h5A, 8'h01, 16'h005A};
    vecs[4] = '{8'h01, 8'hFF, 16'h00FF};
    vecs[5] = '{8'h80, 8'h80, 16'h4000};
    vecs[6] = '{8'h7F, 8'h01, 16'h007F};
    vecs[7] = '{8'h37, 8'h80, 16'h1B80};

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].prod, 1'b0);
      wait_done();
    end

    // start held through completion: next op accepted in the IDLE cycle right after FIN
    issue(8'h05, 8'h07, 16'h0023, 1'b1);
    wait_done();
    op_a = 8'h02; op_b = 8'h03;
    @(negedge clk);
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    sb.push_back('{16'h0006, exp_lat(8'h03)});
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accept_busy", 32'(busy), 32'd1);
    wait_done();

    // reset during cycle 7 of a multiply
    issue(8'h0D, 8'h0B, 16'h008F, 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_product", 32'(product), 32'd0);
    chk("mid_rst_ula", 32'({ula_inA, ula_inB}), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit saw_done = 1'b0;
      repeat (20) begin @(negedge clk); if (done) saw_done = 1'b1; end
      chk("no_done_after_rst", 32'(saw_done), 32'd0);
    end
    issue(8'h10, 8'h10, 16'h0100, 1'b0);
    wait_done();

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom); b = 8'($urandom);
      issue(a, b, 16'(a) * 16'(b), 1'b0);
      wait_done();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ula_mul_ctrl.md
ULA_MUL_CTRL -- requirements
Module: ula_mul_ctrl

Interface
REQ-001 Parameters: none; operand width fixed at 8 bits, product width at 16 bits.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new multiply; sampled only in IDLE.
REQ-005 op_a  input  8  multiplicand, unsigned.
REQ-006 op_b  input  8  multiplier, unsigned.
REQ-007 busy  output  1  high while a multiply is in progress.
REQ-008 done  output  1  one-cycle pulse when product is valid.
REQ-009 product  output  16  registered unsigned result; held until next accepted start.
REQ-010 ula_inA  output  8  ULA operand A (accumulator high byte).
REQ-011 ula_inB  output  8  ULA operand B (multiplicand or 0x00).
REQ-012 ula_ctrl  output  3  ULA operation code; always the shared ADD code.
REQ-013 ula_out  input  8  combinational ULA result for the current inputs.

Function
REQ-014 FSM states SHALL be IDLE, ADD, SHIFT, FIN.
REQ-015 IDLE + start=1: latch op_a into mcand, op_b into mplier, clear acc_hi/acc_lo/carry, clear iteration count, go ADD; start=0 stays IDLE.
REQ-016 ADD: ula_inA=acc_hi, ula_inB = mcand if mplier[0]=1 else 0x00; register sum=ula_out and carry=(ula_out < acc_hi, unsigned); go SHIFT.
REQ-017 SHIFT: {carry,acc_hi,acc_lo} shifted right by 1 into {acc_hi,acc_lo} with carry entering acc_hi[7] and acc_hi[0] entering acc_lo[7]; mplier shifted right by 1; count += 1; go ADD if count<8 else FIN.
REQ-018 Outside ADD, ula_inA and ula_inB SHALL be 0x00; ula_ctrl SHALL be the ADD code in every state.
REQ-019 FIN: product={acc_hi,acc_lo}, done=1 for exactly this cycle, go IDLE.
REQ-020 Latency (macro off): start accepted at edge N -> done=1 in cycle N+17, fixed for all operands.
REQ-021 busy SHALL be 1 in ADD, SHIFT, FIN and 0 in IDLE.
REQ-022 start while busy=1 SHALL be ignored; op_a/op_b changes after acceptance SHALL not affect the result.
REQ-023 Back-to-back: start high in the IDLE cycle following FIN SHALL be accepted; no extra dead cycle.
REQ-024 Boundaries: 0xFF*0xFF=0xFE01; 0x00*x=0x0000; x*0x01=x; carry from 0xFF+0xFF SHALL be captured.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, product=0x0000, all internal registers 0, regardless of clk.
REQ-026 Reset mid-operation SHALL abort without a done pulse; first start after release behaves as from power-up.

Configuration
REQ-027 Macro MUL_EARLY_EXIT_EN defined: in SHIFT, if shifted mplier==0, remaining shifts SHALL be applied in one step (acc shifted right by 8-count total) and FSM goes FIN; latency becomes 2*k+1 cycles, k = index of highest set bit of op_b plus 1 (op_b=0 -> k=1).
REQ-028 MUL_EARLY_EXIT_EN undefined: fixed 17-cycle latency per REQ-020; no early-exit logic present.

Structure
REQ-029 ULA operation codes come from the shared define file; FSM state encodings and the iteration limit constant (8) SHALL be added there.
REQ-030 Single module; no sub-module; the ULA is instantiated by the parent and wired through ula_* ports.

Verification
REQ-031 start, op_a=0x0D, op_b=0x0B -> done 17 cycles later, product=0x008F, busy high throughout.
REQ-032 op_a=0xFF, op_b=0xFF -> product=0xFE01 (carry path); op_a=0x00, op_b=0xA5 -> 0x0000.
REQ-033 start held high across completion with new operands 0x02,0x03 -> second op accepted in cycle after FIN, product=0x0006.
REQ-034 rst_n pulsed low at cycle 7 of a multiply -> outputs zero immediately, no done, next op 0x10*0x10=0x0100 correct.
REQ-035 MUL_EARLY_EXIT_EN: op_b=0x01, op_a=0x7F -> done after 3 cycles, product=0x007F; op_b=0x80 -> 17 cycles.
REQ-036 Random 1000 operand pairs, both macro settings -> product equals op_a*op_b; ula_inA/inB zero outside ADD.
